// File: rtl/divu_pkg.sv
// Shared types and defaults for the divu_seq restoring divider.
// Optional build macro: DIVU_SEQ_ZERO_DETECT_EN (see divu_seq.sv).
package divu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DW_DEF = 4;
   localparam int VW_DEF = 2;

   // Step counter must hold values up to DW.
   function automatic int cnt_w(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, report the resulting quotient bit.
module divu_step
   import divu_pkg::*;
#(
   parameter int VW = VW_DEF
) (
   input  logic [VW:0]   pr_in,
   input  logic [VW-1:0] divisor,
   input  logic          bit_in,
   output logic [VW:0]   pr_out,
   output logic          q_bit
);

   logic [VW+1:0] shifted;
   logic [VW:0]   diff;

   // Compare at full shifted width; only the low VW+1 bits are carried forward.
   always_comb begin
      shifted = {pr_in, bit_in};
      q_bit   = (shifted >= {2'b00, divisor});
      diff    = shifted[VW:0] - {1'b0, divisor};
      pr_out  = q_bit ? diff : shifted[VW:0];
   end

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIVU_SEQ_ZERO_DETECT_EN to short-circuit divide-by-zero with div_by_zero flag.
module divu_seq
   import divu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int            CW   = cnt_w(DW);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [VW:0]   pr_q, pr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] quotient_q, quotient_d;
   logic [VW-1:0] remainder_q, remainder_d;
   logic          dbz_q, dbz_d;

   logic [VW:0]   pr_next;
   logic          q_bit;

   divu_step #(.VW(VW)) u_step (
      .pr_in   (pr_q),
      .divisor (dvs_q),
      .bit_in  (dvd_q[DW-1]),
      .pr_out  (pr_next),
      .q_bit   (q_bit)
   );

   // The dividend register doubles as the quotient: dividend bits leave at
   // the top while quotient bits enter at the bottom.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      pr_d        = pr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               pr_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
               busy_d  = 1'b1;
`ifdef DIVU_SEQ_ZERO_DETECT_EN
               if (divisor == '0) begin
                  state_d     = DONE;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  quotient_d  = '1;
                  remainder_d = dividend[VW-1:0];
                  dbz_d       = 1'b1;
               end
`endif
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end

         RUN: begin
            pr_d  = pr_next;
            dvd_d = {dvd_q[DW-2:0], q_bit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               quotient_d  = {dvd_q[DW-2:0], q_bit};
               remainder_d = pr_next[VW-1:0];
               dbz_d       = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      pr_q  <= pr_d;
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq (DW=4, VW=2); honours DIVU_SEQ_ZERO_DETECT_EN.
module tb_divu_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] dividend;
   logic [1:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [1:0] remainder;
   logic       div_by_zero;

   int errors = 0;
   int checks = 0;

`ifdef DIVU_SEQ_ZERO_DETECT_EN
   localparam int   ZLAT = 1;
   localparam logic ZDBZ = 1'b1;
`else
   localparam int   ZLAT = 5;
   localparam logic ZDBZ = 1'b0;
`endif

   divu_seq #(.DW(4), .VW(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives start at the current negedge (cycle 0) and follows the operation
   // to its done pulse; inj>0 re-asserts start with 6/2 during cycle inj.
   task automatic run_op(input logic [3:0] a, input logic [1:0] b,
                         input logic [3:0] eq, input logic [1:0] er,
                         input logic edbz, input int elat, input int inj,
                         input string tag,
                         output logic [3:0] oq, output logic [1:0] orr);
      int   k;
      logic got;
      logic overlap;
      logic busy_ok;
      k        = 0;
      got      = 1'b0;
      overlap  = 1'b0;
      busy_ok  = 1'b1;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      while (!got && k < 20) begin
         @(negedge clk);
         k++;
         if (k == 1) start = 1'b0;
         if (inj != 0 && k == inj) begin
            start    = 1'b1;
            dividend = 4'd6;
            divisor  = 2'd2;
         end
         if (inj != 0 && k == inj + 1) start = 1'b0;
         if (busy && done) overlap = 1'b1;
         if (busy != (k < elat)) busy_ok = 1'b0;
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk(32'(got), 32'd1, {tag, "_done_seen"});
      chk(32'(k), 32'(elat), {tag, "_latency"});
      chk(32'(quotient), 32'(eq), {tag, "_quotient"});
      chk(32'(remainder), 32'(er), {tag, "_remainder"});
      chk(32'(div_by_zero), 32'(edbz), {tag, "_div_by_zero"});
      chk(32'(busy_ok), 32'd1, {tag, "_busy_window"});
      chk(32'(overlap), 32'd0, {tag, "_busy_done_overlap"});
      oq  = quotient;
      orr = remainder;
   endtask

   initial begin
      logic [3:0] oq;
      logic [1:0] orr;
      logic       seen_done;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = 4'd0;
      divisor  = 2'd0;
      @(negedge clk);
      @(negedge clk);
      chk(32'(busy), 32'd0, "rst_busy");
      chk(32'(done), 32'd0, "rst_done");
      chk(32'(quotient), 32'd0, "rst_quotient");
      chk(32'(remainder), 32'd0, "rst_remainder");
      chk(32'(div_by_zero), 32'd0, "rst_dbz");
      rst = 1'b0;
      @(negedge clk);

      run_op(4'd13, 2'd3, 4'd4, 2'd1, 1'b0, 5, 0, "d13_3", oq, orr);
      @(negedge clk);
      run_op(4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 5, 0, "d15_1", oq, orr);
      @(negedge clk);
      run_op(4'd2, 2'd3, 4'd0, 2'd2, 1'b0, 5, 0, "d2_3", oq, orr);
      @(negedge clk);
      chk(32'(done), 32'd0, "done_single_pulse");
      chk(32'(quotient), 32'd0, "result_held_q");
      chk(32'(remainder), 32'd2, "result_held_r");

      run_op(4'd9, 2'd0, 4'd15, 2'd1, ZDBZ, ZLAT, 0, "d9_0", oq, orr);
      @(negedge clk);

      // start during RUN ignored, then a start accepted in the DONE cycle
      run_op(4'd13, 2'd3, 4'd4, 2'd1, 1'b0, 5, 2, "busy_ignore", oq, orr);
      run_op(4'd6, 2'd2, 4'd3, 2'd0, 1'b0, 5, 0, "done_restart", oq, orr);
      @(negedge clk);

      // reset mid-run
      dividend = 4'd11;
      divisor  = 2'd2;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk(32'(busy), 32'd0, "midrst_busy");
      chk(32'(done), 32'd0, "midrst_done");
      chk(32'(quotient), 32'd0, "midrst_quotient");
      chk(32'(remainder), 32'd0, "midrst_remainder");
      chk(32'(div_by_zero), 32'd0, "midrst_dbz");
      rst       = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      chk(32'(seen_done), 32'd0, "midrst_no_done");
      run_op(4'd11, 2'd2, 4'd5, 2'd1, 1'b0, 5, 0, "d11_2_after_rst", oq, orr);
      @(negedge clk);

      // full operand sweep, back to back
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 4; bi++) begin
            if (bi == 0) begin
               run_op(4'(ai), 2'd0, 4'hF, 2'(ai % 4), ZDBZ, ZLAT, 0, "sweep_zero", oq, orr);
            end else begin
               run_op(4'(ai), 2'(bi), 4'(ai / bi), 2'(ai % bi), 1'b0, 5, 0, "sweep", oq, orr);
               chk(32'(int'(oq) * bi + int'(orr)), 32'(ai), "sweep_identity");
               chk(32'(int'(orr) < bi), 32'd1, "sweep_rem_lt_div");
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
